// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg
// Shared definitions for the programmable down-counting timer:
//   - state_t : controller states (IDLE stopped, RUN counting, DONE one-shot expired)
//   - default widths for the count/reload value and the prescale divisor
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH     = 32;
   localparam int DEFAULT_PSC_WIDTH = 8;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler
// Divides the clock down to a tick that fires once every psc_reg+1 enabled
// cycles. The internal counter only advances while enable is high, so a
// paused timer resumes exactly where it left off.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart the divider from zero (wins over enable)
//   enable    : advance the divider this cycle
//   psc_reg   : terminal value of the divider (0 = tick every enabled cycle)
//   tick      : high in the enabled cycle where the divider reaches psc_reg
module timer_prescaler
   import countdown_timer_pkg::*;
#(
   parameter int PSC_WIDTH = DEFAULT_PSC_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [PSC_WIDTH-1:0] psc_reg,
   output logic                 tick
);

   logic [PSC_WIDTH-1:0] psc_cnt;

   // The tick is decoded from the current divider value so the parent can act
   // on it in the same edge that wraps the divider back to zero; this keeps
   // the period at exactly psc_reg+1 cycles with no dead cycle at the wrap.
   assign tick = enable && (psc_cnt == psc_reg);

   // Divider register: clear has priority so a reload or new load always
   // starts a full prescale period; otherwise count up while enabled and
   // wrap to zero on the tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         psc_cnt <= '0;
      end else if (clear) begin
         psc_cnt <= '0;
      end else if (enable) begin
         if (tick) begin
            psc_cnt <= '0;
         end else begin
            psc_cnt <= psc_cnt + PSC_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
// Programmable down-counting timer used as the system tick / watchdog source.
// Loads a start value, decrements once per prescaled tick, and on reaching
// terminal count emits a one-cycle tc pulse and sets a sticky irq that is
// cleared by irq_ack. Periodic mode auto-reloads; one-shot mode parks in DONE.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture load_val (count and reload) and prescale
//   load_val  : start/reload value
//   prescale  : tick every prescale+1 cycles
//   periodic  : 1 = auto-reload on expiry, 0 = one-shot (sampled at expiry)
//   start     : begin/resume counting
//   stop      : pause counting, count and prescaler hold
//   irq_ack   : clear the sticky irq
//   count     : current count value
//   running   : high while in RUN
//   tc        : one-cycle terminal-count pulse
//   irq       : sticky expiry flag
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int PSC_WIDTH = DEFAULT_PSC_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_val,
   input  logic [PSC_WIDTH-1:0] prescale,
   input  logic                 periodic,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 irq_ack,
   output logic [WIDTH-1:0]     count,
   output logic                 running,
   output logic                 tc,
   output logic                 irq
);

   state_t               state;
   logic [WIDTH-1:0]     reload_reg;
   logic [PSC_WIDTH-1:0] psc_reg;
   logic [WIDTH-1:0]     eff_count;
   logic                 psc_clear;
   logic                 psc_enable;
   logic                 tick;
   logic                 expiry;
   logic                 restart_done;

   // The count a start would see this cycle: a same-cycle load takes effect
   // first, so load+start from IDLE starts from the freshly loaded value.
   assign eff_count = load ? load_val : count;

   // Restarting a finished one-shot reuses the reload value; a zero reload
   // would expire immediately, so that start is ignored.
   assign restart_done = (state == DONE) && start && !stop && !load && (reload_reg != '0);

   // The prescaler only runs in RUN and is frozen by stop; load wins over a
   // tick, so the divider is not advanced in a load cycle either (it is
   // cleared instead).
   assign psc_enable = (state == RUN) && !stop && !load;
   assign psc_clear  = load || restart_done;

   // Terminal count is the tick that would take the count from 1 to 0.
   assign expiry = tick && (count == WIDTH'(1));

   assign running = (state == RUN);

   timer_prescaler #(
      .PSC_WIDTH (PSC_WIDTH)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .clear   (psc_clear),
      .enable  (psc_enable),
      .psc_reg (psc_reg),
      .tick    (tick)
   );

   // Controller, count, reload and flag registers. tc defaults low every
   // cycle so it can only ever be a single-cycle pulse. irq is set by expiry
   // before acknowledge is considered, so an ack landing on the same edge as
   // a new expiry cannot lose that expiry. A load is applied up front and the
   // state case only adds the state transitions around it; in RUN the tick
   // path is skipped on a load so the new value is not decremented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         reload_reg <= '0;
         psc_reg    <= '0;
         tc         <= 1'b0;
         irq        <= 1'b0;
      end else begin
         tc <= 1'b0;

         if (expiry) begin
            irq <= 1'b1;
         end else if (irq_ack) begin
            irq <= 1'b0;
         end

         if (load) begin
            count      <= load_val;
            reload_reg <= load_val;
            psc_reg    <= prescale;
         end

         case (state)
            IDLE: begin
               if (start && !stop && (eff_count != '0)) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
               end else if (!load && tick) begin
                  if (count == WIDTH'(1)) begin
                     tc <= 1'b1;
                     if (periodic) begin
                        count <= reload_reg;
                     end else begin
                        count <= '0;
                        state <= DONE;
                     end
                  end else if (count != '0) begin
                     count <= count - WIDTH'(1);
                  end
               end
            end
            DONE: begin
               if (load) begin
                  if (start && !stop && (load_val != '0)) begin
                     state <= RUN;
                  end else begin
                     state <= IDLE;
                  end
               end else if (restart_done) begin
                  state <= RUN;
                  count <= reload_reg;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
// Self-checking bench for countdown_timer. Each stimulus cycle pushes its
// expected outputs onto a scoreboard queue; after the clock edge the front
// entry is popped and compared against the DUT outputs.
module tb_countdown_timer;

   localparam int WIDTH     = 32;
   localparam int PSC_WIDTH = 8;

   typedef struct {
      logic                 ld;
      logic [WIDTH-1:0]     lv;
      logic [PSC_WIDTH-1:0] ps;
      logic                 per;
      logic                 st;
      logic                 sp;
      logic                 ack;
      logic [WIDTH-1:0]     cnt;
      logic                 run;
      logic                 tc;
      logic                 irq;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] cnt;
      logic             run;
      logic             tc;
      logic             irq;
   } exp_t;

   logic                 clk;
   logic                 rst;
   logic                 load;
   logic [WIDTH-1:0]     load_val;
   logic [PSC_WIDTH-1:0] prescale;
   logic                 periodic;
   logic                 start;
   logic                 stop;
   logic                 irq_ack;
   logic [WIDTH-1:0]     count;
   logic                 running;
   logic                 tc;
   logic                 irq;

   int   checks;
   int   errors;
   exp_t exp_q[$];
   vec_t table_v[$];

   countdown_timer #(
      .WIDTH     (WIDTH),
      .PSC_WIDTH (PSC_WIDTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .prescale (prescale),
      .periodic (periodic),
      .start    (start),
      .stop     (stop),
      .irq_ack  (irq_ack),
      .count    (count),
      .running  (running),
      .tc       (tc),
      .irq      (irq)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(input logic ld, input int lv, input int ps, input logic per,
                                  input logic st, input logic sp, input logic ack,
                                  input int cnt, input logic run, input logic tcv, input logic irqv);
      vec_t v;
      v.ld  = ld;
      v.lv  = WIDTH'(lv);
      v.ps  = PSC_WIDTH'(ps);
      v.per = per;
      v.st  = st;
      v.sp  = sp;
      v.ack = ack;
      v.cnt = WIDTH'(cnt);
      v.run = run;
      v.tc  = tcv;
      v.irq = irqv;
      return v;
   endfunction

   // Pops the oldest expectation and compares every output against it.
   task automatic checkOutput(input string name);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: scoreboard empty", name);
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if (count !== e.cnt) begin
         errors++;
         $display("[TB] FAIL %s count: got %0d expected %0d", name, count, e.cnt);
      end
      checks++;
      if (running !== e.run) begin
         errors++;
         $display("[TB] FAIL %s running: got %b expected %b", name, running, e.run);
      end
      checks++;
      if (tc !== e.tc) begin
         errors++;
         $display("[TB] FAIL %s tc: got %b expected %b", name, tc, e.tc);
      end
      checks++;
      if (irq !== e.irq) begin
         errors++;
         $display("[TB] FAIL %s irq: got %b expected %b", name, irq, e.irq);
      end
   endtask

   // Drives one cycle of inputs away from the active edge, records the
   // expected result, then checks just after the edge that samples them.
   task automatic applyStimulus(input vec_t v, input string name);
      exp_t e;
      @(negedge clk);
      load     = v.ld;
      load_val = v.lv;
      prescale = v.ps;
      periodic = v.per;
      start    = v.st;
      stop     = v.sp;
      irq_ack  = v.ack;
      e.cnt = v.cnt;
      e.run = v.run;
      e.tc  = v.tc;
      e.irq = v.irq;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      checkOutput(name);
   endtask

   initial begin
      exp_t e;
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      load     = 1'b0;
      load_val = '0;
      prescale = '0;
      periodic = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      irq_ack  = 1'b0;

      // Table: ld, lv, ps, per, st, sp, ack | cnt, run, tc, irq
      table_v.push_back(mkVec(1, 5, 0, 0, 0, 0, 0,  5, 0, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 1, 0, 0,  5, 1, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,  2, 1, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 1, 0, 0,  5, 1, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,  4, 1, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 1, 0,  4, 0, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 1, 1, 0,  4, 0, 0, 0));
      table_v.push_back(mkVec(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0));
      table_v.push_back(mkVec(1, 2, 0, 0, 1, 0, 0,  2, 1, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1));
      table_v.push_back(mkVec(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      e.cnt = '0; e.run = 1'b0; e.tc = 1'b0; e.irq = 1'b0;
      exp_q.push_back(e);
      checkOutput("reset_state");
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] table vectors");
      for (int i = 0; i < table_v.size(); i++) begin
         applyStimulus(table_v[i], $sformatf("table[%0d]", i));
      end

      // Periodic reload 3, prescale 2: one decrement every 3 cycles, tc
      // every 9. irq acknowledged at cycle 12, and again at cycle 27 where
      // it coincides with an expiry and must stay set.
      $display("[TB] periodic sequence");
      applyStimulus(mkVec(1, 3, 2, 1, 0, 0, 1,  3, 0, 0, 0), "per_load");
      applyStimulus(mkVec(0, 0, 0, 1, 1, 0, 0,  3, 1, 0, 0), "per_start");
      for (int k = 1; k <= 27; k++) begin
         logic ack_k;
         logic irq_k;
         ack_k = (k == 12) || (k == 27);
         irq_k = ((k >= 9) && (k < 12)) || (k >= 18);
         applyStimulus(mkVec(0, 0, 0, 1, 0, 0, ack_k, 3 - ((k / 3) % 3), 1, (k % 9) == 0, irq_k),
                       $sformatf("per_k%0d", k));
      end
      applyStimulus(mkVec(0, 0, 0, 1, 0, 1, 0,  3, 0, 0, 1), "per_stop");

      // Stop after 4 decrements, idle 5 cycles, resume: expires 6 cycles
      // after the restart.
      $display("[TB] stop/resume sequence");
      applyStimulus(mkVec(1, 10, 0, 0, 0, 0, 1,  10, 0, 0, 0), "sr_load");
      applyStimulus(mkVec(0, 0, 0, 0, 1, 0, 0,  10, 1, 0, 0), "sr_start");
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0,  10 - k, 1, 0, 0), $sformatf("sr_run%0d", k));
      end
      applyStimulus(mkVec(0, 0, 0, 0, 0, 1, 0,  6, 0, 0, 0), "sr_stop");
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0,  6, 0, 0, 0), $sformatf("sr_hold%0d", k));
      end
      applyStimulus(mkVec(0, 0, 0, 0, 1, 0, 0,  6, 1, 0, 0), "sr_restart");
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0,  6 - k, 1, 0, 0), $sformatf("sr_resume%0d", k));
      end
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1), "sr_expire");
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1), "sr_tc_low");

      // A load landing on a tick in RUN replaces the count without a decrement.
      $display("[TB] load on tick sequence");
      applyStimulus(mkVec(1, 4, 0, 0, 0, 0, 0,  4, 0, 0, 1), "lt_load");
      applyStimulus(mkVec(0, 0, 0, 0, 1, 0, 0,  4, 1, 0, 1), "lt_start");
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 1), "lt_dec");
      applyStimulus(mkVec(1, 8, 0, 0, 0, 0, 0,  8, 1, 0, 1), "lt_reload");
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0,  7, 1, 0, 1), "lt_dec2");
      applyStimulus(mkVec(0, 0, 0, 0, 0, 1, 0,  7, 0, 0, 1), "lt_stop");

      // Asynchronous reset mid-count clears everything before the next edge.
      $display("[TB] async reset sequence");
      applyStimulus(mkVec(1, 9, 0, 0, 0, 0, 0,  9, 0, 0, 1), "rs_load");
      applyStimulus(mkVec(0, 0, 0, 0, 1, 0, 0,  9, 1, 0, 1), "rs_start");
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0,  8, 1, 0, 1), "rs_dec8");
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0,  7, 1, 0, 1), "rs_dec7");
      #1;
      rst = 1'b1;
      #1;
      e.cnt = '0; e.run = 1'b0; e.tc = 1'b0; e.irq = 1'b0;
      exp_q.push_back(e);
      checkOutput("rs_async");
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(mkVec(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0), "rs_start_ignored");
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0), "rs_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Programmable down-counting timer: the decrementing counterpart to the existing up-counter used for the PC/cycle count. It loads a start value, decrements by one per prescaled tick, and signals terminal count with a one-cycle pulse and a sticky interrupt cleared by acknowledge. It runs in one-shot or periodic (auto-reload) mode and sits beside the CPU core as the system tick / watchdog source.

## Interface
- WIDTH, 32, width of count and reload value
- PSC_WIDTH, 8, width of prescale divisor
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- load  in  1  pulse: capture load_val and prescale
- load_val  in  WIDTH  start/reload value
- prescale  in  PSC_WIDTH  tick every prescale+1 cycles; 0 = every cycle
- periodic  in  1  1 = auto-reload on expiry, 0 = one-shot (sampled at expiry)
- start  in  1  pulse: begin/resume counting
- stop  in  1  pulse: pause counting, count holds
- irq_ack  in  1  clears irq
- count  out  WIDTH  current count value
- running  out  1  high in RUN state
- tc  out  1  one-cycle terminal-count pulse
- irq  out  1  sticky expiry flag

## Operation
- Registers: count, reload_reg, psc_reg, psc_cnt, state, irq, tc. Reset value of all: 0; state IDLE.
- States: IDLE (stopped), RUN (counting), DONE (one-shot expired).
- load (any state): count <= load_val, reload_reg <= load_val, psc_reg <= prescale, psc_cnt <= 0. DONE -> IDLE; RUN stays RUN and counts from new value. load beats tick in the same cycle.
- start: IDLE -> RUN if effective count != 0 (count after same-cycle load); else ignored. DONE -> RUN with count <= reload_reg, psc_cnt <= 0 (ignored if reload_reg == 0). No effect in RUN.
- stop: RUN -> IDLE, count and psc_cnt hold. stop and start in same cycle: stop wins (no state change from IDLE; RUN -> IDLE).
- RUN: psc_cnt increments each cycle; when psc_cnt == psc_reg, tick: psc_cnt <= 0, count decrements.
- Expiry = tick while count == 1: tc <= 1 for one cycle, irq <= 1. periodic=1: count <= reload_reg, stay RUN. periodic=0: count <= 0, RUN -> DONE.
- irq cleared by irq_ack; expiry and irq_ack in same cycle: irq stays 1.
- count never wraps below 0; decrement arithmetic is WIDTH-bit unsigned.
- prescale input is ignored except at load.

## Timing
- All outputs registered; no combinational input-to-output paths.
- start sampled at edge N: running = 1 after N; first decrement at edge N+P+1 (P = psc_reg).
- Value L expires at edge N + L*(P+1); tc and irq high after that edge; tc low after next edge.
- Periodic: tc every reload*(P+1) cycles with no lost cycle at reload.
- stop at edge S then start at edge R: remaining ticks resume with psc_cnt intact; total elapsed = active cycles only.
- rst mid-count: all outputs 0 immediately (asynchronous), state IDLE, reload_reg lost.

## Structure
- Package countdown_timer_pkg: state enum typedef (IDLE, RUN, DONE) and default parameter constants.
- Sub-module timer_prescaler: psc_cnt register, clear/enable inputs, tick output. Top holds FSM, count, reload, irq.

## Test plan
- load_val=5, prescale=0, periodic=0, start -> count 4,3,2,1,0 on consecutive edges; tc one cycle at 0; irq=1; running=0; state DONE.
- load_val=3, prescale=2, periodic=1 -> tc every 9 cycles, count sequence 3,2,1,3,... holding 3 cycles each; irq_ack clears irq, which is set again at next expiry.
- load_val=10, prescale=0, start, stop after 4 cycles, wait 5, start -> count holds 6 while stopped, expires 6 cycles after restart.
- start with count=0 -> stays IDLE, running=0; start and stop same cycle from IDLE -> stays IDLE.
- expiry coincident with irq_ack -> irq remains 1; load coincident with tick in RUN -> count equals new load_val, no decrement.
- Assert rst while count=7 in RUN -> count=0, running=0, irq=0, tc=0 before next edge; start afterward ignored.
